cas_tx_sequencer: RTL and testbench
===================================

Name: cas_tx_sequencer

Overview:
- Sequences a complete cassette save record through the serial ULA: motor on, motor settle, high-tone leader, data phase, trailer, motor off.
- Owns the ULA control-register contents (write strobe plus byte) and the RTS gate that enables the ULA sine synthesiser.
- Sits between host/firmware logic and the serial ULA plus ACIA. Timing is counted in cassette bit periods of TICK_DIV clk cycles, i.e. 1200 baud at 16/13 MHz.

Parameters:
- TICK_DIV, 1024: clk cycles per tick (one 1200-baud bit period); minimum 2.
- MOTOR_SETTLE, 600: ticks spent in SETTLE; minimum 1.
- LEADER_LEN, 6000: ticks of high-tone leader; minimum 1.
- TRAILER_LEN, 1200: ticks of trailer tone; minimum 1.

Ports:
- clk  input  1  fast clock (16/13 MHz).
- nRESET  input  1  reset, asynchronous, active-low.
- start  input  1  request a save record; sampled only in IDLE.
- abort  input  1  terminate the record early; honoured in any non-IDLE state.
- baud_sel  input  3  tx/rx baud code placed in control bits [2:0] and [5:3]; latched on start.
- data_done  input  1  host pulse: last byte has left the ACIA; honoured only in DATA.
- ctrl_data  output  8  ULA control byte: {motor, rs423_sel=0, baud_sel, baud_sel}.
- ctrl_wr  output  1  single-cycle write strobe for ctrl_data.
- rts_n  output  1  drives ULA RTSI; 0 enables tone output.
- data_en  output  1  high while the host may load ACIA bytes.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle pulse on record completion or after abort.
- aborted  output  1  sticky; set on abort, cleared by the next accepted start.
- state  output  3  current state encoding, for debug and verification.

Behaviour:
- Reset values: ctrl_data=8'h00, ctrl_wr=0, rts_n=1, data_en=0, busy=0, done=0, aborted=0, state=IDLE, tick prescaler and tick counter at 0.
- State encodings: IDLE=0, MOTOR_ON=1, SETTLE=2, LEADER=3, DATA=4, TRAILER=5, STOP=6, DONE=7.
- IDLE:
  - start=1 and abort=0 at edge T: latch baud_sel; aborted<=0; state=MOTOR_ON at T+1.
  - start and abort both high: stay in IDLE (abort wins); aborted is unchanged.
- MOTOR_ON (1 cycle): ctrl_data={1,0,baud,baud}; ctrl_wr=1 this cycle only; busy=1. Next state is SETTLE.
- Tick timing:
  - A prescaler counts 0..TICK_DIV-1 and is cleared on entry to each timed state (SETTLE, LEADER, TRAILER).
  - A tick is generated when the prescaler reaches TICK_DIV-1.
  - A tick counter (16-bit) is cleared on entry; the state exits on the tick that brings the count to its length N.
  - A timed state therefore lasts exactly N*TICK_DIV cycles. No wrap-around is possible because N is below 2^16.
- SETTLE: rts_n=1, motor on; runs MOTOR_SETTLE ticks, then LEADER.
- LEADER: rts_n=0 so the ULA emits high tone, since the ACIA TxD idles at mark. Runs LEADER_LEN ticks, then DATA.
- DATA: rts_n=0, data_en=1; no timeout. On data_done=1, data_en drops the next cycle and state becomes TRAILER.
- TRAILER: rts_n=0, data_en=0; runs TRAILER_LEN ticks, then STOP.
- STOP (1 cycle): rts_n=1; ctrl_data bit 7 cleared, other bits held; ctrl_wr=1 for one cycle. Next state is DONE.
- DONE (1 cycle): done=1, then IDLE. busy=0 from IDLE onward.
- abort in SETTLE/LEADER/DATA/TRAILER:
  - Next cycle is STOP: aborted=1, rts_n=1, data_en=0.
  - The in-progress tick count is discarded.
- abort in MOTOR_ON: proceeds to STOP instead of SETTLE; the motor-on write has already occurred.
- abort in STOP/DONE: ignored, but aborted is set.
- Ignored inputs: start while busy; data_done outside DATA.
- ctrl_wr never occurs outside MOTOR_ON and STOP; ctrl_data is held constant between writes.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). No motor-off write is issued; ctrl_data=0 already encodes motor off.

Test Plan (TICK_DIV=4, MOTOR_SETTLE=2, LEADER_LEN=3, TRAILER_LEN=1):
- Reset, then start with baud_sel=3'b001 -> ctrl_wr pulse with ctrl_data=8'h89; SETTLE 8 cycles; LEADER 12 cycles with rts_n=0; data_en=1.
- In DATA, pulse data_done -> data_en=0 next cycle; TRAILER 4 cycles; ctrl_wr with ctrl_data=8'h09; done pulse; busy=0; aborted=0.
- abort on the 5th cycle of LEADER -> STOP next cycle; rts_n=1; ctrl_data=8'h09 written; done pulse; aborted=1 until the next start.
- start and abort together in IDLE -> no ctrl_wr, state stays 0. start pulses during DATA -> no effect. data_done in LEADER -> ignored, LEADER still lasts 12 cycles.
- Assert nRESET=0 mid-DATA -> rts_n=1, data_en=0, ctrl_data=8'h00, state=0 without waiting for a clk edge; a fresh start gives the full sequence again.
- DATA held 1000 cycles with no data_done -> stays in DATA with rts_n=0 and no spurious ctrl_wr.

Source files
------------

// File: rtl/cas_tx_sequencer.sv
// Cassette save-record sequencer: motor on, settle, leader tone, data, trailer, motor off.
// Owns the serial ULA control byte/strobe and the RTS tone gate.
module cas_tx_sequencer #(
  parameter int TICK_DIV     = 1024,
  parameter int MOTOR_SETTLE = 600,
  parameter int LEADER_LEN   = 6000,
  parameter int TRAILER_LEN  = 1200
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] baud_sel,
  input  logic       data_done,
  output logic [7:0] ctrl_data,
  output logic       ctrl_wr,
  output logic       rts_n,
  output logic       data_en,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [2:0] state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MOTOR_ON, S_SETTLE, S_LEADER, S_DATA, S_TRAILER, S_STOP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   tcnt_q, tcnt_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic          aborted_q, aborted_d;

  logic          tick, last_tick, abort_stop;
  logic [15:0]   tlen;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    tlen = 16'd1;
    case (state_q)
      S_SETTLE:  tlen = 16'(MOTOR_SETTLE);
      S_LEADER:  tlen = 16'(LEADER_LEN);
      S_TRAILER: tlen = 16'(TRAILER_LEN);
      default:   tlen = 16'd1;
    endcase
  end

  assign last_tick = tick && (tcnt_q == tlen - 16'd1);

  always_comb begin
    state_d    = state_q;
    presc_d    = '0;
    tcnt_d     = '0;
    ctrl_d     = ctrl_q;
    aborted_d  = aborted_q;
    abort_stop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          ctrl_d    = {1'b1, 1'b0, baud_sel, baud_sel};
          aborted_d = 1'b0;
          state_d   = S_MOTOR_ON;
        end
      end
      S_MOTOR_ON: begin
        if (abort) abort_stop = 1'b1;
        else       state_d    = S_SETTLE;
      end
      S_SETTLE, S_LEADER, S_TRAILER: begin
        if (abort) begin
          abort_stop = 1'b1;
        end else if (last_tick) begin
          // counters left at zero so the next timed state starts clean
          case (state_q)
            S_SETTLE: state_d = S_LEADER;
            S_LEADER: state_d = S_DATA;
            default:  state_d = S_STOP;
          endcase
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          tcnt_d  = tick ? tcnt_q + 16'd1 : tcnt_q;
        end
      end
      S_DATA: begin
        if (abort)          abort_stop = 1'b1;
        else if (data_done) state_d    = S_TRAILER;
      end
      S_STOP: begin
        if (abort) aborted_d = 1'b1;
        state_d = S_DONE;
      end
      default: begin
        if (abort) aborted_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    if (abort_stop) begin
      state_d   = S_STOP;
      aborted_d = 1'b1;
    end
    // motor-off write keeps the baud fields, only bit 7 drops
    if (state_d == S_STOP && state_q != S_STOP) ctrl_d[7] = 1'b0;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      tcnt_q    <= '0;
      ctrl_q    <= 8'h00;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tcnt_q    <= tcnt_d;
      ctrl_q    <= ctrl_d;
      aborted_q <= aborted_d;
    end
  end

  assign ctrl_data = ctrl_q;
  assign ctrl_wr   = (state_q == S_MOTOR_ON) || (state_q == S_STOP);
  assign rts_n     = !((state_q == S_LEADER) || (state_q == S_DATA) || (state_q == S_TRAILER));
  assign data_en   = (state_q == S_DATA);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign aborted   = aborted_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cas_tx_sequencer.sv
// Scoreboard bench for cas_tx_sequencer with short tick/phase lengths.
module tb_cas_tx_sequencer;

  logic       clk = 1'b0;
  logic       nRESET = 1'b0;
  logic       start = 1'b0, abort = 1'b0, data_done = 1'b0;
  logic [2:0] baud_sel = 3'b000;
  logic [7:0] ctrl_data;
  logic       ctrl_wr, rts_n, data_en, busy, done, aborted;
  logic [2:0] state;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] wr_q[$];
  logic       done_q[$];

  localparam logic [2:0] IDLE = 3'd0, MOTOR_ON = 3'd1, SETTLE = 3'd2, LEADER = 3'd3,
                         DATA = 3'd4, TRAILER = 3'd5, STOP = 3'd6;

  cas_tx_sequencer #(.TICK_DIV(4), .MOTOR_SETTLE(2), .LEADER_LEN(3), .TRAILER_LEN(1)) dut (
    .clk(clk), .nRESET(nRESET), .start(start), .abort(abort), .baud_sel(baud_sel),
    .data_done(data_done), .ctrl_data(ctrl_data), .ctrl_wr(ctrl_wr), .rts_n(rts_n),
    .data_en(data_en), .busy(busy), .done(done), .aborted(aborted), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe and done pulse consumes one expected entry
  always @(negedge clk) begin
    if (nRESET && ctrl_wr) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 32'(ctrl_data), 32'hFFFF);
      else chk("ctrl_data_wr", 32'(ctrl_data), 32'(wr_q.pop_front()));
    end
    if (nRESET && done) begin
      if (done_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
      else chk("aborted_at_done", 32'(aborted), 32'(done_q.pop_front()));
    end
  end

  task automatic wait_st(input logic [2:0] st, input string tag);
    int n = 0;
    while (state !== st && n < 2000) begin @(negedge clk); n++; end
    chk(tag, 32'(state), 32'(st));
  endtask

  task automatic run_len(input logic [2:0] st, input int exp, input string tag);
    int n = 0;
    wait_st(st, {tag, "_enter"});
    while (state === st && n < 5000) begin n++; @(negedge clk); end
    chk(tag, n, exp);
  endtask

  task automatic kick(input logic [2:0] b);
    baud_sel = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_data(input string tag);
    wait_st(DATA, {tag, "_data"});
    chk({tag, "_data_en"}, 32'(data_en), 32'd1);
    chk({tag, "_rts_data"}, 32'(rts_n), 32'd0);
    data_done = 1'b1;
    @(negedge clk);
    data_done = 1'b0;
    chk({tag, "_data_en_drop"}, 32'(data_en), 32'd0);
    run_len(TRAILER, 4, {tag, "_trailer_len"});
    wait_st(IDLE, {tag, "_idle"});
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int bad;
    #1;
    chk("rst_ctrl_data", 32'(ctrl_data), 32'h00);
    chk("rst_ctrl_wr", 32'(ctrl_wr), 32'd0);
    chk("rst_rts_n", 32'(rts_n), 32'd1);
    chk("rst_data_en", 32'(data_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    @(negedge clk); @(negedge clk);
    nRESET = 1'b1;
    @(negedge clk);

    // full record, baud 001
    wr_q.push_back(8'h89); wr_q.push_back(8'h09); done_q.push_back(1'b0);
    kick(3'b001);
    chk("motor_on_state", 32'(state), 32'(MOTOR_ON));
    chk("motor_on_busy", 32'(busy), 32'd1);
    run_len(SETTLE, 8, "settle_len");
    chk("leader_rts", 32'(rts_n), 32'd0);
    run_len(LEADER, 12, "leader_len");
    finish_data("rec1");
    chk("rec1_aborted", 32'(aborted), 32'd0);

    // abort on 5th LEADER cycle
    wr_q.push_back(8'h89); wr_q.push_back(8'h09); done_q.push_back(1'b1);
    kick(3'b001);
    wait_st(LEADER, "ab_leader");
    repeat (4) @(negedge clk);
    chk("ab_still_leader", 32'(state), 32'(LEADER));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_stop", 32'(state), 32'(STOP));
    chk("ab_rts", 32'(rts_n), 32'd1);
    chk("ab_aborted", 32'(aborted), 32'd1);
    wait_st(IDLE, "ab_idle");
    chk("ab_sticky", 32'(aborted), 32'd1);

    // start+abort together in IDLE: no record, aborted unchanged
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("sa_state", 32'(state), 32'(IDLE));
    chk("sa_aborted", 32'(aborted), 32'd1);

    // baud 101; data_done in LEADER ignored, start in DATA ignored, long DATA hold
    wr_q.push_back(8'hAD); wr_q.push_back(8'h2D); done_q.push_back(1'b0);
    kick(3'b101);
    chk("rec2_aborted_clr", 32'(aborted), 32'd0);
    wait_st(LEADER, "rec2_leader");
    data_done = 1'b1;
    fork begin @(negedge clk); data_done = 1'b0; end join_none
    run_len(LEADER, 12, "rec2_leader_len");
    wait_st(DATA, "rec2_data");
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("rec2_start_ign", 32'(state), 32'(DATA));
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (state !== DATA || rts_n !== 1'b0) bad++;
    end
    chk("rec2_data_hold", bad, 0);
    finish_data("rec2");

    // async reset mid-DATA, then fresh record
    wr_q.push_back(8'h89);
    kick(3'b001);
    wait_st(DATA, "rst_mid_data");
    #2 nRESET = 1'b0;
    #1;
    chk("amid_rts", 32'(rts_n), 32'd1);
    chk("amid_data_en", 32'(data_en), 32'd0);
    chk("amid_ctrl", 32'(ctrl_data), 32'h00);
    chk("amid_state", 32'(state), 32'd0);
    @(negedge clk);
    nRESET = 1'b1;
    @(negedge clk);
    wr_q.push_back(8'h89); wr_q.push_back(8'h09); done_q.push_back(1'b0);
    kick(3'b001);
    run_len(SETTLE, 8, "rec3_settle_len");
    run_len(LEADER, 12, "rec3_leader_len");
    finish_data("rec3");

    repeat (3) @(negedge clk);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
